// File: rtl/cpu_mul_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mul_pkg
//   Definitions shared by the iterative MUL unit and its adder.
//   - mul_state_t : controller state encoding (IDLE, RUN, DONE)
//   - MUL_WIDTH   : default operand width
//   - MUL_CNT_W   : width of the iteration counter for MUL_WIDTH operands
// ---------------------------------------------------------------------------
package cpu_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH = 16;
    localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

endpackage

// File: rtl/adder_core.sv
// ---------------------------------------------------------------------------
// adder_core
//   WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
//   Ports:
//     a    in  WIDTH  first operand
//     b    in  WIDTH  second operand
//     cin  in  1      carry into bit 0
//     sum  out WIDTH  a + b + cin, modulo 2^WIDTH
//     cout out 1      carry out of the most significant bit
// ---------------------------------------------------------------------------
module adder_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign sum[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier16.sv
// ---------------------------------------------------------------------------
// seq_multiplier16
//   Iterative shift-and-add unsigned multiplier for the MUL instruction.
//   One partial-product step per clock, WIDTH steps per operation, using a
//   single WIDTH-bit ripple-carry adder (adder_core).
//
//   Ports:
//     clk     in  1        rising-edge clock
//     rst_n   in  1        asynchronous active-low reset
//     start   in  1        request; accepted whenever the unit is not in RUN
//     op_a    in  WIDTH    multiplicand, captured on accept
//     op_b    in  WIDTH    multiplier, captured on accept
//     busy    out 1        high while iterating (RUN)
//     done    out 1        one-cycle pulse: product is valid
//     product out 2*WIDTH  result, held until the next operation completes
//
//   Build option:
//     MUL_ZERO_BYPASS_EN - when defined, an operation with a zero operand
//                          jumps straight to DONE on the accept edge with
//                          product 0 and never raises busy. When undefined,
//                          zero operands run the full WIDTH-step sequence.
// ---------------------------------------------------------------------------
module seq_multiplier16
    import cpu_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t state;
    mul_state_t state_nxt;

    logic [WIDTH-1:0]   mcand;
    // Partial-product register: upper half accumulates, lower half holds the
    // not-yet-consumed multiplier bits. After each shift the adder carry lands
    // in bit 2W-1, so no extra guard bit is needed to hold it.
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_nxt;
    logic [CNT_W-1:0]   count;

    logic               accept;
    logic               bypass;
    logic               last;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // A new request is taken in IDLE and also in DONE, which allows
    // back-to-back operations without an idle gap.
    assign accept = start && (state != RUN);
    assign last   = (count == CNT_W'(WIDTH - 1));

`ifdef MUL_ZERO_BYPASS_EN
    assign bypass = (op_a == '0) || (op_b == '0);
`else
    assign bypass = 1'b0;
`endif

    // Add the multiplicand only when the current multiplier bit is set.
    assign add_b = p[0] ? mcand : '0;

    adder_core #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (p[2*WIDTH-1:WIDTH]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign p_nxt = {add_cout, add_sum, p[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = bypass ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = bypass ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Datapath: operand capture, shift-and-add iteration, result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            p       <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= op_a;
            p     <= {{WIDTH{1'b0}}, op_b};
            count <= '0;
            // A bypassed operation enters DONE directly, so its result
            // (zero) has to be published on this same edge.
            if (bypass) begin
                product <= '0;
            end
        end else if (state == RUN) begin
            p     <= p_nxt;
            count <= count + 1'b1;
            if (last) begin
                product <= p_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier16.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier16
//   Scoreboard bench for seq_multiplier16. Stimulus pushes the hand-computed
//   product and the cycle in which done is due; a monitor pops and compares
//   on every done pulse. Honours MUL_ZERO_BYPASS_EN for zero-operand latency.
// ---------------------------------------------------------------------------
module tb_seq_multiplier16;

    localparam int W = 16;

`ifdef MUL_ZERO_BYPASS_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = 16;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
        string          name;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   pass_cnt;
    int   total_cnt;

    seq_multiplier16 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the unit able to accept. lat is the number of
    // RUN cycles expected (0 for a bypassed zero operation).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, input int lat, input string name);
        exp_t e;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        e.prod = exp;
        e.cyc  = cyc + 1 + lat;
        e.name = name;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk({"busy_after_accept_", name}, {63'd0, busy}, {63'd0, (lat != 0)});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk({"product_", e.name}, product, e.prod);
                    chk({"latency_", e.name}, cyc, e.cyc);
                    chk({"busy_at_done_", e.name}, {63'd0, busy}, 64'd0);
                end
            end
        end
    end

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;

        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_product", product, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'd3, 16'd5, 32'h0000000F, 16, "3x5");
        wait_drain();
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, "ffffxffff");
        wait_drain();
        issue(16'h8000, 16'h0002, 32'h00010000, 16, "8000x2");
        wait_drain();
        issue(16'h1234, 16'h0001, 32'h00001234, 16, "1234x1");
        wait_drain();
        issue(16'h0000, 16'hABCD, 32'h00000000, ZLAT, "0xabcd");
        wait_drain();

        // Busy rejection: second request at RUN cycle 5 must be ignored.
        issue(16'd7, 16'd9, 32'd63, 16, "7x9");
        repeat (4) @(negedge clk);
        op_a  = 16'd2;
        op_b  = 16'd2;
        start = 1'b1;
        chk("busy_during_reject", {63'd0, busy}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Back-to-back: start held high, second op accepted in the DONE cycle.
        begin
            exp_t e;
            bit   seen;
            op_a  = 16'd10;
            op_b  = 16'd10;
            start = 1'b1;
            e.prod = 32'd100;
            e.cyc  = cyc + 17;
            e.name = "b2b_10x10";
            q.push_back(e);
            @(negedge clk);
            op_a = 16'd20;
            op_b = 16'd20;
            seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1'b1;
            end
            chk("b2b_first_done_seen", {63'd0, seen}, 64'd1);
            e.prod = 32'd400;
            e.cyc  = cyc + 17;
            e.name = "b2b_20x20";
            q.push_back(e);
            @(negedge clk);
            start = 1'b0;
            chk("b2b_busy_no_gap", {63'd0, busy}, 64'd1);
            wait_drain();
        end
        chk("product_hold", product, 32'd400);

        // Asynchronous reset between clock edges clears outputs at once.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_busy", {63'd0, busy}, 64'd0);
        chk("async_reset_done", {63'd0, done}, 64'd0);
        chk("async_reset_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset abort at RUN cycle 8: no done may follow.
        op_a  = 16'd7;
        op_b  = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_product_after", product, 64'd0);

        issue(16'h1234, 16'h0003, 32'h0000369C, 16, "after_abort");
        wait_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
